// File: rtl/jtframe_nvram_upload.sv
// jtframe_nvram_upload
// ---------------------------------------------------------------------------
// Serves MiSTer NVRAM uploads (core -> HPS/SD). Each single-cycle HPS byte-read
// request (ioctl_rd) becomes a level/ack handshake on the game's NVRAM read
// port. The byte comes back on ioctl_din, and ioctl_wait stalls hps_io until
// that byte is valid. While an NVRAM upload session is open, busy is high so
// the game can hold off its own NVRAM writes.
//
// Optional build macro: JTFRAME_NVRAM_PREFETCH_EN
//   When it is defined, the byte after each served address is read in the
//   background into a one-byte buffer. A sequential read that hits the buffer
//   is then answered on the next cycle without stalling. When it is undefined,
//   every request goes through a stalled fetch.
//
// Ports
//   clk_sys       system clock
//   rst           asynchronous, active-high reset
//   ioctl_upload  upload in progress (from hps_io)
//   ioctl_index   file index of the transfer
//   ioctl_rd      single-cycle byte-read request
//   ioctl_addr    byte address, sampled with ioctl_rd
//   ioctl_din     byte returned to hps_io
//   ioctl_wait    stall to hps_io (combinational)
//   ram_addr      NVRAM read address
//   ram_rd        NVRAM read request, level, held until ram_ack
//   ram_ack       single-cycle acknowledge, ram_dout valid in the same cycle
//   ram_dout      NVRAM read data
//   busy          upload session active; the game must suspend NVRAM writes
//   err           sticky error flag (fetch timeout or protocol violation),
//                 cleared when a new upload session starts
// ---------------------------------------------------------------------------
module jtframe_nvram_upload #(
  parameter int         AW        = 13,
  parameter logic [7:0] IDX_NVRAM = 8'd2,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic          ram_ack,
  input  logic [7:0]    ram_dout,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  // NVRAM size. One extra bit lets the full 25-bit address be compared
  // without any modulo wrap.
  localparam logic [25:0] RAM_SIZE = 26'd1 << AW;
  // The counter starts at 0 on entry to FETCH, so ram_rd stays high for
  // exactly TIMEOUT cycles when no ack ever arrives.
  localparam logic [7:0]  CNT_LAST = TIMEOUT - 8'd1;

  state_t        state;
  logic [7:0]    cnt;
  logic          active;
  logic          active_q;
  logic          req;      // read request inside an NVRAM session
  logic          req_in;   // ... and addressing existing NVRAM
  logic [AW-1:0] req_addr;
  logic          quiet;    // nothing in flight and nothing queued

  assign active   = ioctl_upload && (ioctl_index == IDX_NVRAM);
  assign req      = ioctl_rd && active;
  assign req_in   = req && ({1'b0, ioctl_addr} < RAM_SIZE);
  assign req_addr = ioctl_addr[AW-1:0];

`ifdef JTFRAME_NVRAM_PREFETCH_EN
  logic          bg;        // current FETCH is a background prefetch
  logic          pend;      // a demand request waits for the prefetch to drain
  logic [AW-1:0] pend_addr;
  logic          pf_valid;
  logic          pf_kill;   // the in-flight prefetch will not be kept
  logic [AW-1:0] pf_addr;
  logic [7:0]    pf_buf;
  logic          pf_hit;
  logic          join_bg;   // request targets the byte being prefetched
  logic          demand;    // the FETCH result goes to hps_io

  assign pf_hit  = (state == IDLE) && !pend && req_in && pf_valid &&
                   (req_addr == pf_addr);
  assign join_bg = (state == FETCH) && bg && !pend && req_in &&
                   (req_addr == ram_addr);
  assign demand  = !bg || join_bg;
  assign quiet   = (state == IDLE) && !pend;

  // A background fetch stalls nobody. A request that arrives during it stalls
  // from its own cycle, either by joining the fetch or by queueing behind it.
  assign ioctl_wait = ((state == IDLE) && req_in && !pf_hit) ||
                      ((state == FETCH) && (!bg || req_in)) ||
                      pend;
`else
  assign quiet      = (state == IDLE);
  assign ioctl_wait = ((state == IDLE) && req_in) || (state == FETCH);
`endif

  // NOTE: every register below is written with non-blocking assignments, so
  // all of them update together from pre-edge values regardless of statement
  // order. Later assignments in the block still take priority over earlier
  // ones, which is how protocol-error sets override the session-start clear.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ioctl_din <= '0;
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      active_q  <= 1'b0;
`ifdef JTFRAME_NVRAM_PREFETCH_EN
      bg        <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pf_valid  <= 1'b0;
      pf_kill   <= 1'b0;
      pf_addr   <= '0;
      pf_buf    <= '0;
`endif
    end else begin
      active_q <= active;

      // The session opens on the rising edge of active. It closes only once
      // the handshake has finished, so ram_rd is never abandoned mid-fetch.
      if (active && !active_q) begin
        busy <= 1'b1;
        err  <= 1'b0;
      end else if (!active && quiet) begin
        busy <= 1'b0;
      end

      case (state)
        IDLE: begin
`ifdef JTFRAME_NVRAM_PREFETCH_EN
          if (pend) begin
            // The prefetch has drained, so serve the queued request now.
            ram_addr <= pend_addr;
            ram_rd   <= 1'b1;
            cnt      <= '0;
            bg       <= 1'b0;
            pend     <= 1'b0;
            state    <= FETCH;
            if (ioctl_rd) err <= 1'b1;
          end else if (pf_hit) begin
            ioctl_din <= pf_buf;
            pf_valid  <= 1'b0;
            if (pf_addr != '1) begin
              ram_addr <= pf_addr + AW'(1);
              ram_rd   <= 1'b1;
              cnt      <= '0;
              bg       <= 1'b1;
              pf_kill  <= 1'b0;
              state    <= FETCH;
            end
          end else if (req_in) begin
            pf_valid <= 1'b0;
            ram_addr <= req_addr;
            ram_rd   <= 1'b1;
            cnt      <= '0;
            bg       <= 1'b0;
            state    <= FETCH;
          end else if (req) begin
            ioctl_din <= 8'hFF;
            pf_valid  <= 1'b0;
          end
`else
          if (req_in) begin
            ram_addr <= req_addr;
            ram_rd   <= 1'b1;
            cnt      <= '0;
            state    <= FETCH;
          end else if (req) begin
            // Out of range: answered at once with FF, no RAM access.
            ioctl_din <= 8'hFF;
          end
`endif
        end

        FETCH: begin
`ifdef JTFRAME_NVRAM_PREFETCH_EN
          if (bg && !pend) begin
            // The HPS saw no stall, so a request here is legal.
            if (join_bg) begin
              bg <= 1'b0;
            end else if (req_in) begin
              pend      <= 1'b1;
              pend_addr <= req_addr;
              pf_kill   <= 1'b1;
            end else if (req) begin
              ioctl_din <= 8'hFF;
              pf_kill   <= 1'b1;
            end
          end else if (ioctl_rd) begin
            err <= 1'b1;
          end

          if (ram_ack) begin
            ram_rd <= 1'b0;
            if (demand) begin
              ioctl_din <= ram_dout;
              state     <= DONE;
            end else begin
              pf_buf   <= ram_dout;
              pf_addr  <= ram_addr;
              pf_valid <= active && !pf_kill && !req;
              state    <= IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            ram_rd <= 1'b0;
            if (demand) begin
              ioctl_din <= 8'hFF;
              err       <= 1'b1;
              state     <= DONE;
            end else begin
              // A failed prefetch only loses the buffer.
              pf_valid <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
`else
          // ioctl_wait is high here, so any request is a protocol violation.
          if (ioctl_rd) err <= 1'b1;

          if (ram_ack) begin
            ioctl_din <= ram_dout;
            ram_rd    <= 1'b0;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            ioctl_din <= 8'hFF;
            ram_rd    <= 1'b0;
            err       <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end

        DONE: begin
          if (ioctl_rd) err <= 1'b1;
`ifdef JTFRAME_NVRAM_PREFETCH_EN
          if (active && (ram_addr != '1)) begin
            ram_addr <= ram_addr + AW'(1);
            ram_rd   <= 1'b1;
            cnt      <= '0;
            bg       <= 1'b1;
            pf_kill  <= 1'b0;
            pf_valid <= 1'b0;
            state    <= FETCH;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase

`ifdef JTFRAME_NVRAM_PREFETCH_EN
      if (!active) pf_valid <= 1'b0;
`endif
    end
  end

endmodule
